// File: rtl/kv_store_arbiter_if.sv
// Request, key-value store and response channels shared between the arbiter
// (master) and the requesters/store/response sink (slave).
interface kv_store_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_key;
  logic [32*NUM_REQ-1:0] req_value;
  logic [NUM_REQ-1:0]    req_kind;

  logic        kv_ram_enable;
  logic        kv_write_enable;
  logic [1:0]  kv_signal;
  logic [31:0] kv_key;
  logic [31:0] kv_value;
  logic [31:0] kv_transact_value;
  logic        kv_transact_kind;
  logic [31:0] kv_updated_value;
  logic [31:0] kv_value_addr;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_BITS-1:0] rsp_id;
  logic [31:0]        rsp_data;
  logic [31:0]        rsp_addr;
  logic               rsp_err;

  modport master (
    input  req_valid, req_op, req_key, req_value, req_kind,
    output req_ready,
    output kv_ram_enable, kv_write_enable, kv_signal, kv_key, kv_value,
           kv_transact_value, kv_transact_kind,
    input  kv_updated_value, kv_value_addr,
    output rsp_valid, rsp_id, rsp_data, rsp_addr, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_key, req_value, req_kind,
    input  req_ready,
    input  kv_ram_enable, kv_write_enable, kv_signal, kv_key, kv_value,
           kv_transact_value, kv_transact_kind,
    output kv_updated_value, kv_value_addr,
    input  rsp_valid, rsp_id, rsp_data, rsp_addr, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/kv_store_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one cuckoo-hash
// store, holding each command for OP_LATENCY cycles before sampling its result.
module kv_store_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_BITS    = 2,
  parameter int OP_LATENCY = 100
) (
  input  logic        clock,
  input  logic        reset_n,
  kv_store_arbiter_if.master bus,
  output logic        busy,
  output logic [31:0] op_count
);

  localparam int CNT_W = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OP_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_reg;
  logic [ID_BITS-1:0] ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic [1:0]  op_arr  [NUM_REQ];
  logic [31:0] key_arr [NUM_REQ];
  logic [31:0] val_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]  = bus.req_op[2*gi +: 2];
      assign key_arr[gi] = bus.req_key[32*gi +: 32];
      assign val_arr[gi] = bus.req_value[32*gi +: 32];
    end
  endgenerate

  logic [NUM_REQ-1:0] grant;
  logic [ID_BITS-1:0] grant_idx;
  logic [ID_BITS-1:0] scan_idx;
  logic               grant_any;

  // First valid requester at or after the pointer, wrapping; reset forces no grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (state_reg == IDLE && reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = ID_BITS'((int'(ptr_reg) + k) % NUM_REQ);
        if (!grant_any && bus.req_valid[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          grant_idx       = scan_idx;
          grant_any       = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign busy          = (state_reg != IDLE);

  logic [1:0]  sel_op;
  logic [31:0] sel_key;
  logic [31:0] sel_val;
  logic        sel_kind;

  assign sel_op   = op_arr[grant_idx];
  assign sel_key  = key_arr[grant_idx];
  assign sel_val  = val_arr[grant_idx];
  assign sel_kind = bus.req_kind[grant_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg             <= IDLE;
      ptr_reg               <= '0;
      count_reg             <= '0;
      bus.kv_ram_enable     <= 1'b0;
      bus.kv_write_enable   <= 1'b0;
      bus.kv_signal         <= 2'd0;
      bus.kv_key            <= '0;
      bus.kv_value          <= '0;
      bus.kv_transact_value <= '0;
      bus.kv_transact_kind  <= 1'b0;
      bus.rsp_valid         <= 1'b0;
      bus.rsp_id            <= '0;
      bus.rsp_data          <= '0;
      bus.rsp_addr          <= '0;
      bus.rsp_err           <= 1'b0;
      op_count              <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            ptr_reg    <= ID_BITS'((int'(grant_idx) + 1) % NUM_REQ);
            bus.rsp_id <= grant_idx;
            if (sel_op == 2'd3) begin
              // Illegal opcode never touches the store; answer immediately.
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_addr  <= '0;
              bus.rsp_valid <= 1'b1;
              state_reg     <= RESP;
            end else begin
              bus.kv_ram_enable     <= 1'b1;
              bus.kv_write_enable   <= (sel_op != 2'd0);
              bus.kv_signal         <= sel_op;
              bus.kv_key            <= sel_key;
              bus.kv_value          <= (sel_op == 2'd1) ? sel_val : 32'd0;
              bus.kv_transact_value <= (sel_op == 2'd2) ? sel_val : 32'd0;
              bus.kv_transact_kind  <= (sel_op == 2'd2) && sel_kind;
              bus.rsp_err           <= 1'b0;
              count_reg             <= CNT_LOAD;
              state_reg             <= BUSY;
            end
          end
        end
        BUSY: begin
          if (count_reg == '0) begin
            // The store has no done flag: its outputs are trusted only here.
            bus.rsp_data          <= bus.kv_updated_value;
            bus.rsp_addr          <= bus.kv_value_addr;
            bus.rsp_valid         <= 1'b1;
            bus.kv_ram_enable     <= 1'b0;
            bus.kv_write_enable   <= 1'b0;
            bus.kv_signal         <= 2'd0;
            bus.kv_key            <= '0;
            bus.kv_value          <= '0;
            bus.kv_transact_value <= '0;
            bus.kv_transact_kind  <= 1'b0;
            state_reg             <= RESP;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            op_count      <= op_count + 32'd1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kv_store_arbiter.sv
// Directed bench for kv_store_arbiter: grants, store window, responses,
// backpressure and asynchronous reset, with a trivial store model.
module tb_kv_store_arbiter;
  localparam int L = 100;

  logic        clock;
  logic        reset_n;
  logic        busy;
  logic [31:0] op_count;
  int          tests;
  int          fails;
  int          exp_ops;

  kv_store_arbiter_if #(.NUM_REQ(4), .ID_BITS(2)) bus ();

  kv_store_arbiter #(.NUM_REQ(4), .ID_BITS(2), .OP_LATENCY(L)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy),
    .op_count(op_count)
  );

  // Store model: result is a fixed function of the key being presented.
  assign bus.kv_updated_value = bus.kv_key ^ 32'hA5A5_0000;
  assign bus.kv_value_addr    = bus.kv_key + 32'h0000_1000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] i, input logic [1:0] op, input logic [31:0] key,
                         input logic [31:0] val, input logic kind);
    bus.req_op[2*int'(i) +: 2]     = op;
    bus.req_key[32*int'(i) +: 32]  = key;
    bus.req_value[32*int'(i) +: 32] = val;
    bus.req_kind[i]                = kind;
    bus.req_valid[i]               = 1'b1;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_kv_en", 32'(bus.kv_ram_enable), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", op_count, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_ops = 0;
    #1;
  endtask

  // Hand over one command from requester g and follow it to acceptance.
  task automatic serve(input logic [1:0] g, input logic [1:0] sig, input logic [31:0] key,
                       input logic [31:0] val, input logic [31:0] tval, input logic tkind,
                       input logic err, input logic [31:0] data, input logic [31:0] addr,
                       input int hold);
    logic [3:0] onehot;
    logic       bad;
    int         n;
    onehot = 4'b0001 << g;
    check("grant", 32'(bus.req_ready), 32'(onehot));
    if (hold > 0) bus.rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    bus.req_valid[g] = 1'b0;
    check("kv_en", 32'(bus.kv_ram_enable), err ? 32'd0 : 32'd1);
    check("kv_we", 32'(bus.kv_write_enable), 32'(!err && sig != 2'd0));
    check("kv_signal", 32'(bus.kv_signal), err ? 32'd0 : 32'(sig));
    check("kv_key", bus.kv_key, err ? 32'd0 : key);
    check("kv_value", bus.kv_value, val);
    check("kv_tval", bus.kv_transact_value, tval);
    check("kv_tkind", 32'(bus.kv_transact_kind), 32'(tkind));
    n   = 0;
    bad = 1'b0;
    while (!bus.rsp_valid && n < L + 10) begin
      if (bus.kv_ram_enable !== 1'b1 || bus.kv_key !== key || busy !== 1'b1) bad = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    check("latency", 32'(n), err ? 32'd0 : 32'(L));
    check("window_stable", 32'(bad), 32'd0);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_id", 32'(bus.rsp_id), 32'(g));
    check("rsp_data", bus.rsp_data, data);
    check("rsp_addr", bus.rsp_addr, addr);
    check("rsp_err", 32'(bus.rsp_err), 32'(err));
    check("kv_en_off", 32'(bus.kv_ram_enable), 32'd0);
    if (hold > 0) begin
      bad = 1'b0;
      for (int c = 0; c < hold; c++) begin
        @(posedge clock);
        #1;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== data || bus.rsp_addr !== addr ||
            bus.rsp_id !== g || bus.req_ready !== 4'b0 || busy !== 1'b1) bad = 1'b1;
      end
      check("backpressure_stable", 32'(bad), 32'd0);
      bus.rsp_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    exp_ops++;
    check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("rsp_err_drop", 32'(bus.rsp_err), 32'd0);
    check("op_count", op_count, 32'(exp_ops));
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_ops = 0;
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_key   = '0;
    bus.req_value = '0;
    bus.req_kind  = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    reset_pulse();

    // Single insert from req0.
    set_req(2'd0, 2'd1, 32'd279, 32'd7623, 1'b0);
    #1;
    serve(2'd0, 2'd1, 32'd279, 32'd7623, 32'd0, 1'b0, 1'b0, 32'hA5A5_0117, 32'h0000_1117, 0);

    // Contention from a fresh pointer.
    reset_pulse();
    set_req(2'd0, 2'd0, 32'd524, 32'd0, 1'b0);
    set_req(2'd1, 2'd0, 32'd249, 32'd0, 1'b0);
    set_req(2'd2, 2'd0, 32'd279, 32'd0, 1'b0);
    set_req(2'd3, 2'd0, 32'd100, 32'd0, 1'b0);
    #1;
    serve(2'd0, 2'd0, 32'd524, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_020C, 32'h0000_120C, 0);
    serve(2'd1, 2'd0, 32'd249, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_00F9, 32'h0000_10F9, 0);
    serve(2'd2, 2'd0, 32'd279, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_0117, 32'h0000_1117, 0);
    serve(2'd3, 2'd0, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_0064, 32'h0000_1064, 0);

    // Pointer back at 0 with req0 idle: req1 wins, then req3 over a new req0.
    set_req(2'd1, 2'd0, 32'd777, 32'd0, 1'b0);
    set_req(2'd3, 2'd0, 32'd888, 32'd0, 1'b0);
    #1;
    serve(2'd1, 2'd0, 32'd777, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_0309, 32'h0000_1309, 0);
    set_req(2'd0, 2'd0, 32'd555, 32'd0, 1'b0);
    #1;
    serve(2'd3, 2'd0, 32'd888, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_0378, 32'h0000_1378, 0);
    serve(2'd0, 2'd0, 32'd555, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_022B, 32'h0000_122B, 0);

    // Transact credit from req2.
    set_req(2'd2, 2'd2, 32'd249, 32'd100, 1'b1);
    #1;
    serve(2'd2, 2'd2, 32'd249, 32'd0, 32'd100, 1'b1, 1'b0, 32'hA5A5_00F9, 32'h0000_10F9, 0);

    // Illegal opcode from req3.
    set_req(2'd3, 2'd3, 32'd5, 32'd9, 1'b0);
    #1;
    serve(2'd3, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 0);

    // Backpressure on req1 with req2 pending, then req2 right after release.
    set_req(2'd1, 2'd0, 32'd524, 32'd0, 1'b0);
    set_req(2'd2, 2'd0, 32'd249, 32'd0, 1'b0);
    #1;
    serve(2'd1, 2'd0, 32'd524, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_020C, 32'h0000_120C, 50);
    serve(2'd2, 2'd0, 32'd249, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_00F9, 32'h0000_10F9, 0);

    // Reset while BUSY at countdown 40; pointer wraps 3 -> 0 first.
    set_req(2'd0, 2'd0, 32'd100, 32'd0, 1'b0);
    set_req(2'd2, 2'd0, 32'd249, 32'd0, 1'b0);
    #1;
    check("wrap_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clock);
    #1;
    repeat (59) @(posedge clock);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_kv_key", bus.kv_key, 32'd100);
    reset_n = 1'b0;
    #1;
    check("async_kv_en", 32'(bus.kv_ram_enable), 32'd0);
    check("async_kv_key", bus.kv_key, 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_ready", 32'(bus.req_ready), 32'd0);
    check("async_rsp", 32'(bus.rsp_valid), 32'd0);
    check("async_op_count", op_count, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    reset_n = 1'b1;
    exp_ops = 0;
    #1;
    serve(2'd0, 2'd0, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_0064, 32'h0000_1064, 0);
    serve(2'd2, 2'd0, 32'd249, 32'd0, 32'd0, 1'b0, 1'b0, 32'hA5A5_00F9, 32'h0000_10F9, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
